// File: rtl/d_flipflop.sv
// ---------------------------------------------------------------------------
// d_flipflop
//   Parameterised D-type register chain. This is a delay line with no
//   enable: every rising clk edge moves d into stage 1 and moves each stage
//   into the next one. q is the last stage.
//
//   Parameters
//     WIDTH        data width of d and q (1..64)
//     RESET_VALUE  value loaded into every stage by reset. Only the low
//                  WIDTH bits are used.
//     STAGES       number of register stages between d and q (1..16)
//
//   Ports
//     clk    in   1      single clock, rising edge only
//     reset  in   1      synchronous, active-high
//     d      in   WIDTH  data input, sampled at the rising edge
//     q      out  WIDTH  output, driven straight from the last stage
//
//   Reset reaches the data stages as well as control. A reset edge has to
//   flush in-flight data, so no stale sample can appear at q after reset.
//   No value is assigned at power-on, so the stages simulate as X until the
//   first reset edge.
// ---------------------------------------------------------------------------
module d_flipflop #(
  parameter int          WIDTH       = 1,
  parameter logic [63:0] RESET_VALUE = 64'd0,
  parameter int          STAGES      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("d_flipflop: WIDTH must be in 1..64");
  end
  if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
    $error("d_flipflop: STAGES must be in 1..16");
  end

  // stage_p[0] is stage 1 (nearest d); stage_p[STAGES-1] drives q.
  logic [WIDTH-1:0] stage_p [STAGES];

  // Pipeline stage boundary: d -> stage 1 -> ... -> stage STAGES
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_p[i] <= RST_V;
      end
    end else begin
      stage_p[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_p[i] <= stage_p[i-1];
      end
    end
  end

  assign q = stage_p[STAGES-1];

endmodule

// File: tb/tb_d_flipflop.sv
`timescale 1ns/1ps
module tb_d_flipflop;

  logic       clk = 1'b0;
  logic       ra, da;
  logic [0:0] qa;
  logic       rb;
  logic [7:0] db, qb;
  logic [3:0] dc, qc;

  always #5 clk = ~clk;

  // A: default 1-bit, 1 stage, reset 0
  d_flipflop u_a (.clk(clk), .reset(ra), .d(da), .q(qa));

  // B: 3-stage byte pipeline with reset value A5
  d_flipflop #(.WIDTH(8), .RESET_VALUE(64'hA5), .STAGES(3)) u_b (
    .clk(clk), .reset(rb), .d(db), .q(qb));

  // C: reset value wider than WIDTH, so only the low nibble is kept
  d_flipflop #(.WIDTH(4), .RESET_VALUE(64'h1234), .STAGES(2)) u_c (
    .clk(clk), .reset(rb), .d(dc), .q(qc));

  int n_pass  = 0;
  int n_total = 0;

  logic [0:0] exp_a [$];
  string      nm_a  [$];
  logic [7:0] exp_b [$];
  string      nm_b  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Monitors: the DUTs present a new output after every rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_a.size() > 0) check(nm_a.pop_front(), {63'd0, qa}, {63'd0, exp_a.pop_front()});
  end

  always @(posedge clk) begin
    #1;
    if (exp_b.size() > 0) check(nm_b.pop_front(), {56'd0, qb}, {56'd0, exp_b.pop_front()});
  end

  task automatic step_a(input logic r, input logic dv, input logic e, input string name);
    ra = r; da = dv;
    exp_a.push_back(e); nm_a.push_back(name);
    @(negedge clk);
  endtask

  task automatic step_b(input logic r, input logic [7:0] dv, input logic [7:0] e, input string name);
    rb = r; db = dv;
    exp_b.push_back(e); nm_b.push_back(name);
    @(negedge clk);
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    ra = 1'b1; da = 1'b0;
    rb = 1'b1; db = 8'h00; dc = 4'hF;

    // Initial reset and release
    step_a(1'b1, 1'b0, 1'b0, "a_init_reset");
    step_a(1'b0, 1'b0, 1'b0, "a_release_d0");
    // Data capture
    step_a(1'b0, 1'b1, 1'b1, "a_cap_1");
    step_a(1'b0, 1'b1, 1'b1, "a_hold_1");
    step_a(1'b0, 1'b0, 1'b0, "a_cap_0");
    step_a(1'b0, 1'b0, 1'b0, "a_hold_0");
    step_a(1'b0, 1'b1, 1'b1, "a_cap_1b");
    step_a(1'b0, 1'b1, 1'b1, "a_hold_1b");
    // Reset asserted at 80 ns must not touch q before the 85 ns edge
    ra = 1'b1; da = 1'b1;
    exp_a.push_back(1'b0); nm_a.push_back("a_sync_reset");
    #2 check("a_reset_between_edges", {63'd0, qa}, 64'd1);
    @(negedge clk);
    step_a(1'b0, 1'b1, 1'b1, "a_after_reset");
    step_a(1'b0, 1'b0, 1'b0, "a_cap_0c");
    // Glitch on d between edges
    ra = 1'b0; da = 1'b0;
    exp_a.push_back(1'b0); nm_a.push_back("a_d_glitch_edge");
    #2 da = 1'b1;
    #2 da = 1'b0;
    check("a_d_glitch_mid", {63'd0, qa}, 64'd0);
    @(negedge clk);
    // Glitch on reset between edges
    ra = 1'b0; da = 1'b1;
    exp_a.push_back(1'b1); nm_a.push_back("a_reset_glitch");
    #2 ra = 1'b1;
    #2 ra = 1'b0;
    @(negedge clk);

    // Pipeline depth on the 3-stage instance
    step_b(1'b1, 8'h00, 8'hA5, "b_reset1");
    check("c_reset_trunc_1", {60'd0, qc}, 64'h4);
    step_b(1'b1, 8'h00, 8'hA5, "b_reset_held");
    check("c_reset_trunc_2", {60'd0, qc}, 64'h4);
    step_b(1'b0, 8'h01, 8'hA5, "b_fill1");
    step_b(1'b0, 8'h02, 8'hA5, "b_fill2");
    step_b(1'b0, 8'h03, 8'h01, "b_out01");
    step_b(1'b0, 8'h04, 8'h02, "b_out02");
    step_b(1'b0, 8'h05, 8'h03, "b_out03");
    // Mid-stream reset with 04/05 still in flight
    step_b(1'b1, 8'h06, 8'hA5, "b_mid_reset");
    step_b(1'b0, 8'h07, 8'hA5, "b_flush1");
    step_b(1'b0, 8'h08, 8'hA5, "b_flush2");
    step_b(1'b0, 8'h09, 8'h07, "b_out07");
    step_b(1'b0, 8'hFF, 8'h08, "b_out08");
    step_b(1'b0, 8'h00, 8'h09, "b_out09");
    step_b(1'b0, 8'h5A, 8'hFF, "b_outFF");
    step_b(1'b0, 8'h5A, 8'h00, "b_out00");
    step_b(1'b0, 8'h5A, 8'h5A, "b_out5A");

    // Let the monitors drain, then make sure nothing was left unchecked
    repeat (2) @(negedge clk);
    check("a_queue_drained", 64'(exp_a.size()), 64'd0);
    check("b_queue_drained", 64'(exp_b.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
